// File: rtl/burst_planner_pkg.sv
// ---------------------------------------------------------------------------
// burst_planner_pkg
// Shared definitions for the burst_len_planner block:
//   - state_t       : planner FSM states (IDLE, MUL, DIV, ISSUE, GAP, DONE)
//   - WSIZE         : internal arithmetic width for pixel/word products
//   - MODE_LINE/ONCE: MODE parameter values (4-character strings)
//   - clog2()       : constant ceiling-log2 helper for elaboration-time sizing
// ---------------------------------------------------------------------------
package burst_planner_pkg;

  localparam int WSIZE = 48;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MUL   = 3'd1,
    DIV   = 3'd2,
    ISSUE = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [31:0] MODE_LINE = "LINE";
  localparam logic [31:0] MODE_ONCE = "ONCE";

  // Ceiling log2; clog2(1) = 0 so a 1-bit AXI word degenerates to no shift.
  function automatic int clog2(input longint unsigned value);
    longint unsigned v;
    int r;
    r = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_words_calc.sv
// ---------------------------------------------------------------------------
// seg_words_calc
// Converts a segment pixel count into AXI words, rounding up.
//   Stage 1 (registered on start): prod = pixels * DSIZE.
//   Stage 2 (combinational from the product register): words =
//     ceil(prod / AXI_DSIZE), done as a shift plus a carry for any remainder.
//   The caller registers 'words' in the cycle 'valid' is high.
// Ports:
//   clock, rst_n : clock and asynchronous active-low reset
//   start        : one-cycle request; pixels is sampled on this cycle
//   pixels       : segment pixel count (WSIZE bits)
//   valid        : product register holds the result of the last start
//   words        : rounded-up word count for the registered product
// ---------------------------------------------------------------------------
module seg_words_calc
  import burst_planner_pkg::*;
#(
  parameter int AXI_DSIZE = 256,
  parameter int DSIZE     = 24
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WSIZE-1:0] pixels,
  output logic             valid,
  output logic [WSIZE-1:0] words
);

  localparam int               SHIFT    = clog2(AXI_DSIZE);
  localparam logic [WSIZE-1:0] DSIZE_W  = WSIZE'(DSIZE);
  // Low bits that fall below one AXI word; any of them set means a partial word.
  localparam logic [WSIZE-1:0] REM_MASK = (WSIZE'(1) << SHIFT) - WSIZE'(1);

  logic [WSIZE-1:0] prod_q, prod_d;
  logic             valid_q, valid_d;

  always_comb begin
    prod_d  = prod_q;
    valid_d = start;
    if (start) begin
      prod_d = pixels * DSIZE_W;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      valid_q <= valid_d;
    end
  end

  assign valid = valid_q;
  assign words = (prod_q >> SHIFT) + WSIZE'(|(prod_q & REM_MASK));

endmodule

// File: rtl/burst_len_planner.sv
// ---------------------------------------------------------------------------
// burst_len_planner
// Splits a hactive x vactive frame into AXI bursts of NOR_BURST_LEN words
// plus one shorter tail per segment (a line in "LINE" mode, the whole frame
// in "ONCE" mode). Each burst is presented with burst_valid and held until
// the consumer pulses burst_done. fsync at any time restarts the frame.
//
// Optional feature macro: BURST_PLANNER_PERF_CNT_EN
//   defined   : frame_burst_cnt counts accepted bursts (saturating, cleared
//               by fsync, held after frame_done)
//   undefined : frame_burst_cnt is tied to zero
//
// Ports:
//   clock, rst_n    : clock, asynchronous active-low reset
//   vactive,hactive : frame geometry, captured on fsync
//   fsync           : one-cycle frame start / restart
//   burst_done      : consumer accepts the presented burst
//   burst_valid     : burst descriptor presented
//   burst_len       : words in the presented burst
//   tail_status     : presented burst is shorter than NOR_BURST_LEN
//   line_last       : presented burst ends its segment
//   frame_last      : presented burst ends the frame
//   frame_done      : one-cycle pulse after the final burst is accepted
//   busy            : frame in progress
//   frame_burst_cnt : accepted bursts this frame (optional feature)
// ---------------------------------------------------------------------------
module burst_len_planner
  import burst_planner_pkg::*;
#(
  parameter int          NOR_BURST_LEN = 200,
  parameter logic [31:0] MODE          = MODE_LINE,
  parameter int          AXI_DSIZE     = 256,
  parameter int          DSIZE         = 24,
  parameter int          LSIZE         = 9
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [15:0]      vactive,
  input  logic [15:0]      hactive,
  input  logic             fsync,
  input  logic             burst_done,
  output logic             burst_valid,
  output logic [LSIZE-1:0] burst_len,
  output logic             tail_status,
  output logic             line_last,
  output logic             frame_last,
  output logic             frame_done,
  output logic             busy,
  output logic [15:0]      frame_burst_cnt
);

  localparam bit               ONCE_MODE = (MODE == MODE_ONCE);
  localparam logic [WSIZE-1:0] NOR_W     = WSIZE'(NOR_BURST_LEN);

  state_t           state_q, state_d;
  logic [15:0]      hact_q, hact_d;
  logic [15:0]      vact_q, vact_d;
  logic [15:0]      seg_left_q, seg_left_d;
  logic [WSIZE-1:0] seg_words_q, seg_words_d;
  logic [WSIZE-1:0] rem_q, rem_d;

  logic             burst_valid_q, burst_valid_d;
  logic [LSIZE-1:0] burst_len_q, burst_len_d;
  logic             tail_q, tail_d;
  logic             line_last_q, line_last_d;
  logic             frame_last_q, frame_last_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;

  logic [WSIZE-1:0] pixels;
  logic             calc_valid;
  logic [WSIZE-1:0] calc_words;

  // Current burst as seen from the words still owed in this segment.
  logic [WSIZE-1:0] cur_len_w;
  logic             cur_last;
  logic             cur_frame_last;

  assign pixels = ONCE_MODE ? (WSIZE'(hact_q) * WSIZE'(vact_q)) : WSIZE'(hact_q);

  seg_words_calc #(
    .AXI_DSIZE(AXI_DSIZE),
    .DSIZE    (DSIZE)
  ) u_seg_words_calc (
    .clock (clock),
    .rst_n (rst_n),
    .start (state_q == MUL),
    .pixels(pixels),
    .valid (calc_valid),
    .words (calc_words)
  );

  assign cur_len_w      = (rem_q < NOR_W) ? rem_q : NOR_W;
  assign cur_last       = (rem_q <= NOR_W);
  assign cur_frame_last = cur_last && (seg_left_q == 16'd1);

  always_comb begin
    state_d     = state_q;
    hact_d      = hact_q;
    vact_d      = vact_q;
    seg_left_d  = seg_left_q;
    seg_words_d = seg_words_q;
    rem_d       = rem_q;

    if (fsync) begin
      // Restart wins over everything, including a same-cycle burst_done.
      hact_d  = hactive;
      vact_d  = vactive;
      state_d = MUL;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        MUL:  state_d = DIV;
        DIV: begin
          if (calc_valid) begin
            seg_words_d = calc_words;
            rem_d       = calc_words;
            seg_left_d  = ONCE_MODE ? 16'd1 : vact_q;
            state_d     = ((calc_words == '0) || (seg_left_d == 16'd0)) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (burst_done) begin
            if (cur_last) begin
              rem_d      = seg_words_q;
              seg_left_d = seg_left_q - 16'd1;
            end else begin
              rem_d = rem_q - cur_len_w;
            end
            state_d = cur_frame_last ? DONE : GAP;
          end
        end
        GAP:     state_d = ISSUE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Outputs are registered from the next-state view so they line up with
    // the state they describe and stay put while a burst waits in ISSUE.
    burst_valid_d = (state_d == ISSUE);
    burst_len_d   = '0;
    tail_d        = 1'b0;
    line_last_d   = 1'b0;
    frame_last_d  = 1'b0;
    if (burst_valid_d) begin
      burst_len_d  = LSIZE'((rem_d < NOR_W) ? rem_d : NOR_W);
      tail_d       = (rem_d < NOR_W);
      line_last_d  = (rem_d <= NOR_W);
      frame_last_d = line_last_d && (seg_left_d == 16'd1);
    end
    frame_done_d = (state_d == DONE);
    busy_d       = (state_d == MUL) || (state_d == DIV) ||
                   (state_d == ISSUE) || (state_d == GAP);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      hact_q        <= '0;
      vact_q        <= '0;
      seg_left_q    <= '0;
      seg_words_q   <= '0;
      rem_q         <= '0;
      burst_valid_q <= 1'b0;
      burst_len_q   <= '0;
      tail_q        <= 1'b0;
      line_last_q   <= 1'b0;
      frame_last_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hact_q        <= hact_d;
      vact_q        <= vact_d;
      seg_left_q    <= seg_left_d;
      seg_words_q   <= seg_words_d;
      rem_q         <= rem_d;
      burst_valid_q <= burst_valid_d;
      burst_len_q   <= burst_len_d;
      tail_q        <= tail_d;
      line_last_q   <= line_last_d;
      frame_last_q  <= frame_last_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign burst_valid = burst_valid_q;
  assign burst_len   = burst_len_q;
  assign tail_status = tail_q;
  assign line_last   = line_last_q;
  assign frame_last  = frame_last_q;
  assign frame_done  = frame_done_q;
  assign busy        = busy_q;

`ifdef BURST_PLANNER_PERF_CNT_EN
  logic [15:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (fsync) begin
      burst_cnt_d = '0;
    end else if ((state_q == ISSUE) && burst_done && (burst_cnt_q != 16'hFFFF)) begin
      burst_cnt_d = burst_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign frame_burst_cnt = burst_cnt_q;
`else
  assign frame_burst_cnt = '0;
`endif

endmodule

// File: tb/tb_burst_len_planner.sv
// ---------------------------------------------------------------------------
// tb_burst_len_planner
// Three planner instances: 0 = LINE/64, 1 = ONCE/64, 2 = LINE/60
// (AXI_DSIZE 256, DSIZE 24). A behavioural model expands each frame into
// its expected burst list; a vector table, hand sequences (abort, reset,
// zero geometry) and random frames are checked against it.
// ---------------------------------------------------------------------------
module tb_burst_len_planner;

  logic        clk;
  logic        rst_n;
  logic [15:0] vactive;
  logic [15:0] hactive;
  logic        fsync_a [3];
  logic        bdone_a [3];
  logic        bv      [3];
  logic [8:0]  bl      [3];
  logic        ts      [3];
  logic        ll      [3];
  logic        fl      [3];
  logic        fd      [3];
  logic        busy    [3];
  logic [15:0] fbc     [3];

  int total = 0;
  int bad   = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int          N = (gi == 2) ? 60 : 64;
    localparam logic [31:0] M = (gi == 1) ? "ONCE" : "LINE";
    burst_len_planner #(
      .NOR_BURST_LEN(N),
      .MODE         (M),
      .AXI_DSIZE    (256),
      .DSIZE        (24),
      .LSIZE        (9)
    ) u_dut (
      .clock          (clk),
      .rst_n          (rst_n),
      .vactive        (vactive),
      .hactive        (hactive),
      .fsync          (fsync_a[gi]),
      .burst_done     (bdone_a[gi]),
      .burst_valid    (bv[gi]),
      .burst_len      (bl[gi]),
      .tail_status    (ts[gi]),
      .line_last      (ll[gi]),
      .frame_last     (fl[gi]),
      .frame_done     (fd[gi]),
      .busy           (busy[gi]),
      .frame_burst_cnt(fbc[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int len;
    bit tail;
    bit seg_last;
    bit frm_last;
  } exp_t;

  typedef struct {
    int d;
    int h;
    int v;
    int n;
    int last;
  } vec_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int nor_of(input int d);
    return (d == 2) ? 60 : 64;
  endfunction

  // Expected bursts for one frame, straight from the geometry.
  task automatic build_model(input int d, input int h, input int v);
    longint pix, words, w;
    int     n, segs, len;
    exp_t   e;
    exp_q.delete();
    n     = nor_of(d);
    pix   = (d == 1) ? longint'(h) * longint'(v) : longint'(h);
    words = (pix * 24 + 255) / 256;
    segs  = (d == 1) ? 1 : v;
    if (words == 0) segs = 0;
    for (int s = 0; s < segs; s++) begin
      w = words;
      while (w > 0) begin
        len        = (w > n) ? n : int'(w);
        e.len      = len;
        e.tail     = (len < n);
        e.seg_last = (w - len == 0);
        e.frm_last = e.seg_last && (s == segs - 1);
        exp_q.push_back(e);
        w = w - len;
      end
    end
  endtask

  task automatic wait_valid(input int d, input string name);
    int c = 0;
    while (!bv[d] && c < 40) begin
      tick();
      c++;
    end
    check(name, 64'(bv[d]), 64'd1);
  endtask

  function automatic logic [63:0] pack_burst(input int d);
    return {51'd0, bl[d], ts[d], ll[d], fl[d]};
  endfunction

  function automatic logic [63:0] pack_exp(input exp_t e);
    logic [8:0] l9;
    l9 = 9'(e.len);
    return {51'd0, l9, e.tail, e.seg_last, e.frm_last};
  endfunction

  function automatic logic [63:0] pack_all(input int d);
    return {33'd0, bv[d], bl[d], ts[d], ll[d], fl[d], fd[d], busy[d], fbc[d]};
  endfunction

  // Runs one frame on instance d. With pre set, fsync was sampled on the
  // previous edge already (abort case) and the frame continues from there.
  task automatic run_frame(input int d, input int h, input int v, input bit pre,
                           output int n_acc, output int last_len);
    int cyc;
    int hold;
    bit bad_done;
    bit saw_valid;
    bad_done  = 0;
    saw_valid = 0;
    n_acc     = 0;
    last_len  = 0;
    build_model(d, h, v);
    if (!pre) begin
      hactive    = 16'(h);
      vactive    = 16'(v);
      fsync_a[d] = 1'b1;
      tick();
      fsync_a[d] = 1'b0;
    end
    cyc = 1;
    check("busy_after_fsync", 64'(busy[d]), 64'd1);
    foreach (exp_q[i]) begin
      while (!bv[d] && cyc < 40) begin
        if (fd[d]) bad_done = 1;
        tick();
        cyc++;
      end
      if (!bv[d]) begin
        check("valid_timeout", 64'(bv[d]), 64'd1);
        return;
      end
      check((i == 0) ? "first_latency" : "next_latency", 64'(cyc), (i == 0) ? 64'd3 : 64'd2);
      hold = $urandom_range(0, 2);
      for (int k = 0; k <= hold; k++) begin
        check("burst_fields", pack_burst(d), pack_exp(exp_q[i]));
        check("valid_held", 64'(bv[d]), 64'd1);
        if (k < hold) tick();
      end
      last_len   = int'(bl[d]);
      bdone_a[d] = 1'b1;
      tick();
      bdone_a[d] = 1'b0;
      n_acc++;
      cyc = 1;
    end
    if (exp_q.size() == 0) begin
      while (!fd[d] && cyc < 40) begin
        if (bv[d]) saw_valid = 1;
        tick();
        cyc++;
      end
      check("zero_done_latency", 64'(cyc), 64'd3);
      check("zero_no_valid", 64'(saw_valid), 64'd0);
    end else begin
      check("frame_done_after_last", 64'(fd[d]), 64'd1);
      check("valid_low_after_last", 64'(bv[d]), 64'd0);
    end
    tick();
    check("frame_done_one_cycle", 64'(fd[d]), 64'd0);
    check("busy_low_after_done", 64'(busy[d]), 64'd0);
    check("no_early_frame_done", 64'(bad_done), 64'd0);
`ifdef BURST_PLANNER_PERF_CNT_EN
    check("perf_cnt", 64'(fbc[d]), 64'(n_acc));
`else
    check("perf_cnt_tied", 64'(fbc[d]), 64'd0);
`endif
    $display("frame dut=%0d h=%0d v=%0d bursts=%0d last_len=%0d", d, h, v, n_acc, last_len);
  endtask

  vec_t tbl[13];

  initial begin
    int n_acc, last_len;
    int d, h, v;

    tbl[0]  = '{0, 1920, 2, 6, 52};
    tbl[1]  = '{1, 1920, 2, 6, 40};
    tbl[2]  = '{0,   10, 1, 1,  1};
    tbl[3]  = '{0,   11, 1, 1,  2};
    tbl[4]  = '{2, 1920, 1, 3, 60};
    tbl[5]  = '{0,    0, 3, 0,  0};
    tbl[6]  = '{0,    5, 0, 0,  0};
    tbl[7]  = '{1,    0, 5, 0,  0};
    tbl[8]  = '{0,  100, 3, 3, 10};
    tbl[9]  = '{2, 2000, 2, 8,  8};
    tbl[10] = '{1,    1, 1, 1,  1};
    tbl[11] = '{1,  640, 3, 3, 52};
    tbl[12] = '{2, 1280, 1, 2, 60};

    rst_n   = 1'b0;
    vactive = '0;
    hactive = '0;
    for (int i = 0; i < 3; i++) begin
      fsync_a[i] = 1'b0;
      bdone_a[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) check("reset_outputs", pack_all(i), 64'd0);
    rst_n = 1'b1;
    tick();

    // Vector table.
    foreach (tbl[i]) begin
      run_frame(tbl[i].d, tbl[i].h, tbl[i].v, 1'b0, n_acc, last_len);
      check("table_burst_count", 64'(n_acc), 64'(tbl[i].n));
      check("table_last_len", 64'(last_len), 64'(tbl[i].last));
      tick();
    end

    // Ignored burst_done while nothing is presented.
    bdone_a[0] = 1'b1;
    tick();
    bdone_a[0] = 1'b0;
    check("stray_done_idle", {62'd0, bv[0], busy[0]}, 64'd0);

    // Abort: fsync together with burst_done on the second burst.
    hactive    = 16'd1920;
    vactive    = 16'd2;
    fsync_a[0] = 1'b1;
    tick();
    fsync_a[0] = 1'b0;
    wait_valid(0, "abort_first_valid");
    bdone_a[0] = 1'b1;
    tick();
    bdone_a[0] = 1'b0;
    wait_valid(0, "abort_second_valid");
    fsync_a[0] = 1'b1;
    bdone_a[0] = 1'b1;
    tick();
    fsync_a[0] = 1'b0;
    bdone_a[0] = 1'b0;
    check("abort_valid_drop", 64'(bv[0]), 64'd0);
    check("abort_no_frame_done", 64'(fd[0]), 64'd0);
`ifdef BURST_PLANNER_PERF_CNT_EN
    check("abort_cnt_clear", 64'(fbc[0]), 64'd0);
`endif
    run_frame(0, 1920, 2, 1'b1, n_acc, last_len);
    check("abort_restart_count", 64'(n_acc), 64'd6);
    tick();

    // Asynchronous reset while a burst is presented, then vactive = 0.
    hactive    = 16'd1920;
    vactive    = 16'd1;
    fsync_a[0] = 1'b1;
    tick();
    fsync_a[0] = 1'b0;
    wait_valid(0, "reset_issue_valid");
    rst_n = 1'b0;
    #1;
    check("reset_in_issue", pack_all(0), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("after_reset_idle", pack_all(0), 64'd0);
    run_frame(0, 1920, 0, 1'b0, n_acc, last_len);
    check("vactive_zero_count", 64'(n_acc), 64'd0);
    tick();

    // Random frames against the model.
    for (int r = 0; r < 25; r++) begin
      d = $urandom_range(0, 2);
      h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 2500);
      v = $urandom_range(0, 3);
      run_frame(d, h, v, 1'b0, n_acc, last_len);
      check("random_count", 64'(n_acc), 64'(exp_q.size()));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/burst_len_planner.md
Name: burst_len_planner

Overview:
- Next-generation line/frame burst-length generator for the VDMA read and write datapaths.
- Converts a frame of hactive x vactive pixels (DSIZE bits each) into a sequence of AXI burst lengths, in AXI_DSIZE-bit words:
  - full bursts of NOR_BURST_LEN words;
  - one shorter tail burst per segment.
- A segment is a line (LINE mode) or the whole frame (ONCE mode).
- Adds over the previous generation: an explicit valid/done handshake per burst, last-of-line and end-of-frame flags, correct ceiling for non-word-aligned lines, and fsync restart mid-frame.

Parameters:
- NOR_BURST_LEN, 200, normal burst length in AXI words; must satisfy 1 <= NOR_BURST_LEN < 2^LSIZE.
- MODE, "LINE", "LINE" means one segment per line; "ONCE" means one segment per frame.
- AXI_DSIZE, 256, AXI data width in bits; must be a power of two.
- DSIZE, 24, pixel width in bits; any value from 1 to 64.
- LSIZE, 9, width of burst_len.

Ports:
- clock  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- vactive  in  16  lines per frame; sampled on fsync.
- hactive  in  16  pixels per line; sampled on fsync.
- fsync  in  1  single-cycle frame start; also restarts the block.
- burst_done  in  1  consumer pulse accepting the current burst.
- burst_valid  out  1  a burst descriptor is presented.
- burst_len  out  LSIZE  word count of the presented burst.
- tail_status  out  1  presented burst is a tail (len < NOR_BURST_LEN).
- line_last  out  1  presented burst is the last of its segment.
- frame_last  out  1  presented burst is the last of the frame.
- frame_done  out  1  one-cycle pulse after the last burst of the frame is accepted.
- busy  out  1  high from the cycle after fsync until frame_done.
- frame_burst_cnt  out  16  bursts accepted this frame (see Optional Feature).

Behaviour:
- Reset: all outputs 0; state IDLE.
- Internal arithmetic width: 48 bits (localparam).
- Segment length in words:
  - seg_words = ceil(seg_pixels * DSIZE / AXI_DSIZE).
  - seg_pixels = hactive in LINE mode; hactive * vactive in ONCE mode.
  - Division is a right shift by log2(AXI_DSIZE); any nonzero remainder adds 1.
- States:
  - IDLE --fsync--> MUL.
  - MUL: register the product. Next state DIV.
  - DIV: register seg_words and the segment counter (vactive in LINE mode, 1 in ONCE mode). Next state ISSUE, or DONE if seg_words == 0 or the segment count == 0.
  - ISSUE:
    - burst_valid = 1.
    - burst_len = min(rem, NOR_BURST_LEN).
    - tail_status = (rem < NOR_BURST_LEN).
    - line_last = (rem <= NOR_BURST_LEN).
    - frame_last = line_last && (segments_left == 1).
    - On burst_done: rem -= burst_len. If line_last: segments_left--, rem reloads seg_words. Next state GAP, or DONE if frame_last.
  - GAP: one idle cycle with burst_valid = 0. Next state ISSUE.
  - DONE: frame_done = 1 for one cycle. Next state IDLE.
- Outputs are registered; burst_len and the flags stay stable while burst_valid is high.
- Latency:
  - First burst_valid is 3 cycles after fsync is sampled.
  - After an accepting burst_done, the next burst_valid follows 2 cycles later.
- burst_done while burst_valid == 0 is ignored.
- fsync in any state (including the same cycle as burst_done) aborts the frame:
  - the pending burst is not counted;
  - the counters reload and the state goes to MUL;
  - no frame_done is issued for the aborted frame.
- An exact multiple of NOR_BURST_LEN produces no tail: tail_status stays 0 and line_last sits on a full burst.
- hactive or vactive of 0: no bursts; frame_done fires 3 cycles after fsync.

Optional Feature:
- Macro: BURST_PLANNER_PERF_CNT_EN.
- When defined:
  - frame_burst_cnt counts each accepted burst, saturating at 16'hFFFF.
  - It clears on fsync.
  - It holds its value after frame_done until the next fsync.
- When not defined: frame_burst_cnt is tied to 0 and no counter logic is synthesised. The port list is unchanged.

Decomposition:
- Package burst_planner_pkg holds:
  - the state enum (IDLE, MUL, DIV, ISSUE, GAP, DONE);
  - WSIZE = 48;
  - the clog2 helper function;
  - the MODE string constants.
- One natural sub-module: seg_words_calc. It does the two-stage multiply and ceiling shift, with a start/valid interface.

Test Plan:
- LINE mode, NOR_BURST_LEN = 64, hactive = 1920, vactive = 2, DSIZE = 24, AXI_DSIZE = 256:
  - burst sequence 64, 64, 52, 64, 64, 52;
  - tail_status set on each 52; line_last set on each 52; frame_last set only on the final 52;
  - frame_done pulses once.
- ONCE mode, same inputs: sequence 64 x5 then 40, frame_last on the 40.
- Ceiling check, LINE mode, vactive = 1, NOR_BURST_LEN = 64:
  - hactive = 10 gives a single burst of 1;
  - hactive = 11 gives a single burst of 2.
- Exact multiple: NOR_BURST_LEN = 60, hactive = 1920, vactive = 1 → 60, 60, 60 with tail_status never set; line_last on the third burst.
- fsync asserted while the second burst is valid: that burst is not accepted, busy stays high, no frame_done for the aborted frame, and the new sequence restarts 3 cycles later.
  - With BURST_PLANNER_PERF_CNT_EN defined, frame_burst_cnt resets to 0.
- Reset during ISSUE, and vactive = 0: after reset all outputs read 0; with vactive = 0, frame_done arrives at cycle 3 with no burst_valid.
